// File: rtl/frv_bitwise_iter.sv
// ---------------------------------------------------------------------------
// frv_bitwise_iter
//
// Multi-cycle bitwise unit for the execute stage. Funnel shifts (fsl/fsr)
// and the wide rotate (mror) are done iteratively, rotating a 2*XLEN
// working register by at most STEP bits per cycle. cmov and xc.bop are
// combinational and complete in the cycle they are presented.
//
// Ports:
//   g_clk     - clock
//   g_resetn  - asynchronous active-low reset
//   rs1..rs3  - source operands (XLEN bits each)
//   bop_lut   - 8-entry truth table for xc.bop
//   flush     - abort any operation in progress; blocks a new issue
//   valid     - operands valid, held stable until ready or flush
//   uop_*     - one-hot operation select (fsl, fsr, mror, cmov, bop)
//   result    - 2*XLEN result, zero whenever ready is low
//   ready     - result valid this cycle
//   busy      - an iterative operation is in flight
// ---------------------------------------------------------------------------
module frv_bitwise_iter #(
    parameter int XLEN         = 32,
    parameter int STEP         = 8,
    parameter bit XC_CLASS_BIT = 1'b1
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    input  logic [XLEN-1:0]     rs3,
    input  logic [7:0]          bop_lut,
    input  logic                flush,
    input  logic                valid,
    input  logic                uop_fsl,
    input  logic                uop_fsr,
    input  logic                uop_mror,
    input  logic                uop_cmov,
    input  logic                uop_bop,
    output logic [2*XLEN-1:0]   result,
    output logic                ready,
    output logic                busy
);

    localparam int DW = 2 * XLEN;
    localparam int AW = $clog2(DW);

    // Distances carry one extra bit so that STEP == 2*XLEN is representable.
    localparam logic [AW:0] STEP_W = (AW + 1)'(STEP);
    localparam logic [AW:0] DW_W   = (AW + 1)'(DW);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_work;
    logic [AW-1:0]   r_count;
    logic            r_dir;      // 1: rotate left (fsl), 0: rotate right
    logic            r_is_mror;  // result is the full register, not the high half

    logic            w_shift_uop;
    logic            w_load;
    logic            w_abort;
    logic            w_cnt_zero;
    logic [AW-1:0]   w_amt;
    logic [DW-1:0]   w_opw;
    logic [AW:0]     w_cnt_ext;
    logic [AW:0]     w_d;
    logic [AW:0]     w_d_rev;
    logic [DW-1:0]   w_rotl;
    logic [DW-1:0]   w_rotr;
    logic [DW-1:0]   w_rot;
    logic [XLEN-1:0] w_cmov;
    logic [XLEN-1:0] w_bop;
    logic [XLEN-1:0] w_bop_g;

    // ---------------------------------------------------------------
    // Issue decode and operand formation
    // ---------------------------------------------------------------
    assign w_shift_uop = uop_fsl | uop_fsr | uop_mror;
    assign w_load      = (r_state == S_IDLE) & valid & ~flush & w_shift_uop;
    // Losing valid mid-operation is handled exactly like a flush.
    assign w_abort     = flush | ~valid;
    assign w_cnt_zero  = (r_count == '0);
    assign w_amt       = uop_mror ? rs3[AW-1:0] : rs2[AW-1:0];
    assign w_opw       = {rs1, (uop_mror ? rs2 : rs3)};

    // ---------------------------------------------------------------
    // Per-cycle rotate by d = min(count, STEP)
    // ---------------------------------------------------------------
    assign w_cnt_ext = {1'b0, r_count};
    assign w_d       = (w_cnt_ext < STEP_W) ? w_cnt_ext : STEP_W;
    // d == 0 gives a complementary shift of DW, which yields zero and
    // leaves the register unchanged after the OR.
    assign w_d_rev   = DW_W - w_d;
    assign w_rotl    = (r_work << w_d) | (r_work >> w_d_rev);
    assign w_rotr    = (r_work >> w_d) | (r_work << w_d_rev);
    assign w_rot     = r_dir ? w_rotl : w_rotr;

    // ---------------------------------------------------------------
    // Single-cycle operations
    // ---------------------------------------------------------------
    assign w_cmov = (|rs2) ? rs1 : rs3;

    always_comb begin
        w_bop = '0;
        for (int i = 0; i < XLEN; i++) begin
            w_bop[i] = bop_lut[{rs1[i], rs2[i], rs3[i]}];
        end
    end

    assign w_bop_g = XC_CLASS_BIT ? w_bop : '0;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_abort || w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        ready  = 1'b0;
        result = '0;
        busy   = (r_state == S_BUSY);
        // Gating on the reset input keeps outputs at zero while reset is
        // held, even if a combinational op is presented.
        if (g_resetn) begin
            case (r_state)
                S_IDLE: begin
                    if (valid && !flush) begin
                        if (uop_cmov) begin
                            ready  = 1'b1;
                            result = {{XLEN{1'b0}}, w_cmov};
                        end else if (uop_bop) begin
                            ready  = 1'b1;
                            result = {{XLEN{1'b0}}, w_bop_g};
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_abort && w_cnt_zero) begin
                        ready  = 1'b1;
                        result = r_is_mror ? r_work
                                           : {{XLEN{1'b0}}, r_work[DW-1:XLEN]};
                    end
                end
                default: begin
                    ready  = 1'b0;
                    result = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Working register, remaining distance and latched op attributes
    // ---------------------------------------------------------------
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_work    <= '0;
            r_count   <= '0;
            r_dir     <= 1'b0;
            r_is_mror <= 1'b0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_load) begin
            r_work    <= w_opw;
            r_count   <= w_amt;
            r_dir     <= uop_fsl;
            r_is_mror <= uop_mror;
        end else if (r_state == S_BUSY) begin
            if (!valid) begin
                r_count <= '0;
            end else if (!w_cnt_zero) begin
                r_work  <= w_rot;
                // d never exceeds count, so it fits in AW bits here.
                r_count <= r_count - w_d[AW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_frv_bitwise_iter.sv
// ---------------------------------------------------------------------------
// tb_frv_bitwise_iter
//
// Scoreboard bench: every issued operation pushes its expected result and
// the cycle in which ready must appear; a monitor on the falling edge pops
// and compares whenever ready is high. A second instance with xc.bop
// disabled shares the inputs.
// ---------------------------------------------------------------------------
module tb_frv_bitwise_iter;

    localparam int XLEN = 32;
    localparam int STEP = 8;
    localparam int DW   = 2 * XLEN;

    localparam int K_FSL  = 0;
    localparam int K_FSR  = 1;
    localparam int K_MROR = 2;
    localparam int K_CMOV = 3;
    localparam int K_BOP  = 4;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic [XLEN-1:0] rs3 = '0;
    logic [7:0]      bop_lut = '0;
    logic            flush = 1'b0;
    logic            valid = 1'b0;
    logic            uop_fsl = 1'b0;
    logic            uop_fsr = 1'b0;
    logic            uop_mror = 1'b0;
    logic            uop_cmov = 1'b0;
    logic            uop_bop = 1'b0;
    logic [DW-1:0]   result;
    logic            ready;
    logic            busy;
    logic [DW-1:0]   result_nb;
    logic            ready_nb;
    logic            busy_nb;

    frv_bitwise_iter #(.XLEN(XLEN), .STEP(STEP), .XC_CLASS_BIT(1'b1)) u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .rs1(rs1), .rs2(rs2), .rs3(rs3), .bop_lut(bop_lut),
        .flush(flush), .valid(valid),
        .uop_fsl(uop_fsl), .uop_fsr(uop_fsr), .uop_mror(uop_mror),
        .uop_cmov(uop_cmov), .uop_bop(uop_bop),
        .result(result), .ready(ready), .busy(busy)
    );

    frv_bitwise_iter #(.XLEN(XLEN), .STEP(STEP), .XC_CLASS_BIT(1'b0)) u_dut_nobop (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .rs1(rs1), .rs2(rs2), .rs3(rs3), .bop_lut(bop_lut),
        .flush(flush), .valid(valid),
        .uop_fsl(uop_fsl), .uop_fsr(uop_fsr), .uop_mror(uop_mror),
        .uop_cmov(uop_cmov), .uop_bop(uop_bop),
        .result(result_nb), .ready(ready_nb), .busy(busy_nb)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: rotation as bit-index arithmetic modulo 2*XLEN.
    function automatic logic [63:0] model(int kind, logic [31:0] a, logic [31:0] b,
                                          logic [31:0] c, logic [7:0] lut);
        logic [63:0] w;
        logic [63:0] r;
        int          amt;
        int          idx;
        r = '0;
        if (kind == K_CMOV) begin
            r = {32'h0, ((b != 0) ? a : c)};
        end else if (kind == K_BOP) begin
            for (int i = 0; i < 32; i++) begin
                idx  = 4 * int'(a[i]) + 2 * int'(b[i]) + int'(c[i]);
                r[i] = lut[idx];
            end
        end else begin
            amt = (kind == K_MROR) ? int'(c % 64) : int'(b % 64);
            w   = {a, ((kind == K_MROR) ? b : c)};
            for (int i = 0; i < 64; i++) begin
                if (kind == K_FSL) r[(i + amt) % 64] = w[i];
                else               r[i] = w[(i + amt) % 64];
            end
            if (kind != K_MROR) r = {32'h0, r[63:32]};
        end
        return r;
    endfunction

    function automatic int lat(int kind, logic [31:0] b, logic [31:0] c);
        int amt;
        if (kind == K_CMOV || kind == K_BOP) return 0;
        amt = (kind == K_MROR) ? int'(c % 64) : int'(b % 64);
        return 1 + (amt + STEP - 1) / STEP;
    endfunction

    task automatic set_uops(int kind);
        uop_fsl  = (kind == K_FSL);
        uop_fsr  = (kind == K_FSR);
        uop_mror = (kind == K_MROR);
        uop_cmov = (kind == K_CMOV);
        uop_bop  = (kind == K_BOP);
    endtask

    // Issue one operation (called just after a rising edge), hold it until
    // ready or a cycle budget runs out, then leave valid low.
    task automatic do_op(string name, int kind, logic [31:0] a, logic [31:0] b,
                         logic [31:0] c, logic [7:0] lut, logic [63:0] exp_res);
        int start;
        int l;
        bit got;
        exp_t e;
        l      = lat(kind, b, c);
        start  = cyc;
        e.res  = exp_res;
        e.cyc  = start + l;
        e.name = name;
        sb.push_back(e);
        rs1 = a; rs2 = b; rs3 = c; bop_lut = lut;
        set_uops(kind);
        valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge g_clk);
            check({name, "_busy"}, 64'(busy), 64'((kind <= K_MROR) && (cyc > start)));
            if (ready === 1'b1) begin
                got = 1'b1;
                if (kind == K_BOP) begin
                    check({name, "_nobop_ready"}, 64'(ready_nb), 64'd1);
                    check({name, "_nobop_result"}, result_nb, 64'd0);
                end
            end
        end
        if (!got) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s_timeout: ready never seen, expected at cycle %0d", name, start + l);
        end
        @(posedge g_clk);
        #1;
        valid = 1'b0;
        set_uops(-1);
    endtask

    // Monitor: pop and compare on every ready; result must be zero otherwise.
    always @(negedge g_clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, result, mon_e.res);
                check({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end else begin
            check("result_zero_when_not_ready", result, 64'd0);
        end
    end

    initial begin : stim
        int          start;
        int          kind;
        int          gap;
        logic [31:0] a, b, c;
        logic [7:0]  lut;

        repeat (2) @(negedge g_clk);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        do_op("t1_mror5", K_MROR, 32'h00000001, 32'h0, 32'd5, 8'h0, 64'h00000000_08000000);
        do_op("t2_fsl4", K_FSL, 32'h80000001, 32'd4, 32'hF0000000, 8'h0, 64'h00000000_0000001F);
        do_op("t3_fsr63", K_FSR, 32'h12345678, 32'd63, 32'h9ABCDEF0, 8'h0, 64'h00000000_2468ACF1);
        do_op("t4_mror0", K_MROR, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'd0, 8'h0, 64'hA5A5A5A5_5A5A5A5A);
        do_op("t4_cmov_z", K_CMOV, 32'h11111111, 32'h0, 32'h22222222, 8'h0, 64'h00000000_22222222);
        do_op("t4_cmov_nz", K_CMOV, 32'h11111111, 32'h00000100, 32'h22222222, 8'h0, 64'h00000000_11111111);
        do_op("t4_bop", K_BOP, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 8'h96, 64'h00000000_F00FF00F);

        // Flush three cycles into an amt=40 fsr, then issue immediately.
        start = cyc;
        rs1 = 32'hDEADBEEF; rs2 = 32'd40; rs3 = 32'hCAFEF00D;
        set_uops(K_FSR);
        valid = 1'b1;
        repeat (3) @(posedge g_clk);
        #1 flush = 1'b1;
        @(negedge g_clk);
        check("t5_busy_in_flush_cycle", 64'(busy), 64'd1);
        check("t5_flush_cycle", 64'(cyc), 64'(start + 3));
        @(posedge g_clk);
        #1 flush = 1'b0;
        valid = 1'b0;
        set_uops(-1);
        do_op("t5_mror8", K_MROR, 32'h000000FF, 32'h0, 32'd8, 8'h0, 64'h00000000_FF000000);

        // A combinational op alongside flush must not complete.
        rs1 = 32'h1; rs2 = 32'h0; rs3 = 32'h2;
        set_uops(K_CMOV);
        valid = 1'b1;
        flush = 1'b1;
        @(negedge g_clk);
        check("flush_cmov_ready", 64'(ready), 64'd0);
        @(posedge g_clk);
        #1 flush = 1'b0;
        valid = 1'b0;
        set_uops(-1);

        // valid dropping while busy aborts without a result.
        rs1 = 32'h13579BDF; rs2 = 32'd30; rs3 = 32'h2468ACE0;
        set_uops(K_FSL);
        valid = 1'b1;
        repeat (2) @(posedge g_clk);
        #1 valid = 1'b0;
        set_uops(-1);
        @(negedge g_clk);
        check("vdrop_ready", 64'(ready), 64'd0);
        @(negedge g_clk);
        check("vdrop_idle_busy", 64'(busy), 64'd0);
        @(posedge g_clk);
        #1;

        // Asynchronous reset in cycle 2 of an amt=63 fsr.
        rs1 = 32'h12345678; rs2 = 32'd63; rs3 = 32'h9ABCDEF0;
        set_uops(K_FSR);
        valid = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;
        check("t6_busy_before_reset", 64'(busy), 64'd1);
        #2 g_resetn = 1'b0;
        #1;
        check("t6_reset_ready", 64'(ready), 64'd0);
        check("t6_reset_busy", 64'(busy), 64'd0);
        check("t6_reset_result", result, 64'd0);
        valid = 1'b0;
        set_uops(-1);
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge g_clk);
            check("t6_idle_after_release", 64'(busy), 64'd0);
        end
        @(posedge g_clk);
        #1;
        do_op("t6_fsr63", K_FSR, 32'h12345678, 32'd63, 32'h9ABCDEF0, 8'h0, 64'h00000000_2468ACF1);

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 4));
            a    = $urandom;
            b    = $urandom;
            c    = $urandom;
            lut  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                if (kind == K_MROR) c = {c[31:6], 6'($urandom_range(0, 9))};
                else                b = {b[31:6], 6'($urandom_range(0, 9))};
            end
            if (kind == K_CMOV && $urandom_range(0, 3) == 0) b = 32'h0;
            do_op("rand", kind, a, b, c, lut, model(kind, a, b, c, lut));
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(posedge g_clk);
                #1;
            end
        end

        repeat (3) @(negedge g_clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/frv_bitwise_iter.md
Name: frv_bitwise_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle bitwise unit in the SCARV core execute stage.
- Supports XLEN-generic funnel shifts (fsl/fsr) and the wide rotate (mror), computed iteratively at STEP bits per cycle to save area.
- Keeps cmov and xc.bop as single-cycle operations.
- Uses the same valid/ready/flush contract as the other execute-stage functional units.

Parameters:
- XLEN, 32: operand width; result is 2*XLEN.
- STEP, 8: maximum rotate distance per iteration. Power of two, 1..2*XLEN.
- XC_CLASS_BIT, 1: enables xc.bop; when 0, the bop result is forced to 0.
- AW (derived), log2(2*XLEN): shift-amount width, 6 for XLEN=32.

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- rs1  in  XLEN  source 1
- rs2  in  XLEN  source 2
- rs3  in  XLEN  source 3
- bop_lut  in  8  truth table for xc.bop
- flush  in  1  abort any operation in progress
- valid  in  1  inputs valid; held stable until ready or flush
- uop_fsl  in  1  funnel shift left
- uop_fsr  in  1  funnel shift right
- uop_mror  in  1  wide rotate right
- uop_cmov  in  1  conditional move
- uop_bop  in  1  xc.bop
- result  out  2*XLEN  result
- ready  out  1  result valid this cycle
- busy  out  1  iterative operation in flight

Behaviour:
- Clock/reset: one clock, g_clk; asynchronous active-low reset, g_resetn.
- Reset: state=IDLE, working register=0, count=0, direction=0. ready=0, busy=0, result=0.
- uop_* is one-hot whenever valid=1.
- cmov:
  - Combinational: result={0, |rs2 ? rs1 : rs3}.
  - ready=valid in the same cycle, in any state where no shift op is loaded.
- bop:
  - Combinational: result[i]=bop_lut[{rs1[i],rs2[i],rs3[i]}] for i<XLEN; upper half 0.
  - ready=valid in the same cycle.
- Shift ops: amt = mror ? rs3[AW-1:0] : rs2[AW-1:0]. Operand word W = {rs1, mror ? rs2 : rs3}.
  - fsl: result = {0, high XLEN of rotl(W, amt)}.
  - fsr: result = {0, high XLEN of rotr(W, amt)}.
  - mror: result = rotr(W, amt), full 2*XLEN.
- State machine for shift ops:
  - IDLE: valid & shift uop & !flush → load W, count=amt, direction (1 for fsl), then go to BUSY. ready=0 in the load cycle.
  - BUSY, count!=0: rotate the register by d=min(count,STEP) in the latched direction; count-=d. ready=0.
  - BUSY, count==0: ready=1, result driven from the register as above, go to IDLE.
- Latency: the load cycle is cycle 0, and ready is asserted in cycle 1+ceil(amt/STEP).
  - amt=0 → cycle 1.
  - XLEN=32, STEP=8, amt=63 → cycle 9.
- Single-cycle throughput: valid in the cycle after ready is a new operation.
- result=0 whenever ready=0. busy=(state==BUSY).
- flush:
  - Highest priority: any state → IDLE next cycle, count cleared, ready forced 0 in that cycle.
  - A valid in the same cycle as flush is not loaded, including cmov/bop.
- valid dropping while BUSY is treated as flush: abort to IDLE, no ready.
- Reset asserted mid-operation: immediate return to reset values; no ready after release until a new load.
- Rotation is modulo 2*XLEN; amounts wrap naturally within AW bits.

Test Plan (XLEN=32, STEP=8):
1. mror rs1=0x00000001, rs2=0, rs3=5 → ready at cycle 2, result=0x00000000_08000000; busy high for cycles 1-2.
2. fsl rs1=0x80000001, rs3=0xF0000000, rs2=4 → ready at cycle 2, result=0x00000000_0000001F.
3. fsr rs1=0x12345678, rs3=0x9ABCDEF0, rs2=63 → ready at cycle 9 exactly, result=0x00000000_2468ACF1; ready=0 in cycles 0-8.
4. Single-cycle ops:
   - mror amt=0, rs1=0xA5A5A5A5, rs2=0x5A5A5A5A → ready at cycle 1, result=0xA5A5A5A5_5A5A5A5A.
   - cmov rs2=0, rs1=0x11111111, rs3=0x22222222 → ready same cycle, result=0x22222222.
   - bop lut=0x96, rs1=0xFF00FF00, rs2=0x0F0F0F0F, rs3=0 → result=0xF00FF00F; with XC_CLASS_BIT=0 → result=0.
5. Flush mid-operation:
   - fsr amt=40 loaded at cycle 0, flush at cycle 3 → no ready; IDLE at cycle 4, busy=0.
   - mror amt=8 loaded at cycle 4 → ready at cycle 6 with correct result.
6. g_resetn pulsed low asynchronously at cycle 2 of an amt=63 fsr → ready, busy and result drop to 0 immediately; no ready after release until a new valid; the next op completes with correct latency.
